// File: rtl/ring_seq_pkg.sv
// ring_seq_pkg
//   Shared definitions for the ring sequencer: ring advance mode codes and
//   the controller state encoding (binary, 2 bits).
package ring_seq_pkg;

  localparam logic [1:0] MODE_ROT  = 2'b00;  // plain rotate
  localparam logic [1:0] MODE_JOHN = 2'b01;  // Johnson (inverted feedback)
  localparam logic [1:0] MODE_SER  = 2'b10;  // serial shift-in from SIN
  localparam logic [1:0] MODE_HOLD = 2'b11;  // ring frozen, counter still runs

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_FIN  = 2'b11
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == S_LOAD) || (s == S_RUN);
  endfunction

endpackage

// File: rtl/ring_shift_reg.sv
// ring_shift_reg
//   WIDTH-stage ring of D stages. Stage i feeds stage i+1; the feedback into
//   stage 0 is selected by mode.
// Ports:
//   clk   rising-edge clock
//   clr   synchronous clear (highest priority)
//   load  parallel load of seed
//   step  advance the ring one position
//   mode  feedback select (rotate / Johnson / serial / hold)
//   seed  parallel load value
//   sin   serial input used in serial mode
//   q     stage values, bit 0 = first stage
//   qp    complement of q
module ring_shift_reg
  import ring_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             step,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] seed,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qp
);

  logic feed;

  always_comb begin
    feed = q[WIDTH-1];
    case (mode)
      MODE_ROT:  feed = q[WIDTH-1];
      MODE_JOHN: feed = ~q[WIDTH-1];
      MODE_SER:  feed = sin;
      default:   feed = q[WIDTH-1];
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= seed;
    end else if (step && (mode != MODE_HOLD)) begin
      q <= {q[WIDTH-2:0], feed};
    end
  end

  // Complement rail is decoded straight from the stage flops.
  assign qp = ~q;

endmodule

// File: rtl/ring_seq_ctrl.sv
// ring_seq_ctrl
//   Sequencer for a WIDTH-stage ring: captures mode/seed/step count on START,
//   loads the seed, advances the ring the programmed number of steps and
//   flags completion with a one-cycle DONE pulse. ABORT returns to idle with
//   the ring and remaining count frozen.
//
//   state | meaning
//   IDLE  | waiting for START, ring holds
//   LOAD  | ring <= captured seed, REM <= captured step count
//   RUN   | one ring advance and one REM decrement per cycle
//   FIN   | DONE pulse, back to IDLE next cycle
//
// Ports:
//   CLK    rising-edge clock
//   RST    synchronous active-high reset
//   START  begin a sequence (IDLE only)
//   ABORT  stop a sequence without DONE
//   MODE   00 rotate, 01 Johnson, 10 serial, 11 hold (captured on START)
//   SEED   initial ring value (captured on START)
//   STEPS  number of advance steps (captured on START)
//   SIN    serial input for serial mode
//   Q/QP   ring stage values and complement
//   BUSY   high in LOAD and RUN
//   DONE   one-cycle pulse in FIN
//   REM    steps remaining
module ring_seq_ctrl
  import ring_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] SEED,
  input  logic [CNT_W-1:0] STEPS,
  input  logic             SIN,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QP,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] REM
);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        mode_r;
  logic [WIDTH-1:0]  seed_r;
  logic [CNT_W-1:0]  steps_r;
  logic [CNT_W-1:0]  rem_r;
  logic              capture;
  logic              load_en;
  logic              step_en;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ABORT is checked before any load/step so the ring and REM stay exactly
  // where they were when the sequence was stopped.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    load_en   = 1'b0;
    step_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (START && !ABORT) begin
          capture   = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (ABORT) begin
          state_nxt = S_IDLE;
        end else begin
          load_en   = 1'b1;
          state_nxt = (steps_r == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (ABORT) begin
          state_nxt = S_IDLE;
        end else begin
          step_en = 1'b1;
          if (rem_r == CNT_W'(1)) begin
            state_nxt = S_FIN;
          end
        end
      end
      S_FIN: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_r  <= MODE_ROT;
      seed_r  <= '0;
      steps_r <= '0;
    end else if (capture) begin
      mode_r  <= MODE;
      seed_r  <= SEED;
      steps_r <= STEPS;
    end
  end

  // RUN is only entered with a nonzero count and leaves when it reaches 1,
  // so the decrement can never wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rem_r <= '0;
    end else if (load_en) begin
      rem_r <= steps_r;
    end else if (step_en) begin
      rem_r <= rem_r - CNT_W'(1);
    end
  end

  ring_shift_reg #(
    .WIDTH (WIDTH)
  ) u_ring (
    .clk  (CLK),
    .clr  (RST),
    .load (load_en),
    .step (step_en),
    .mode (mode_r),
    .seed (seed_r),
    .sin  (SIN),
    .q    (Q),
    .qp   (QP)
  );

  assign BUSY = is_busy(state);
  assign DONE = (state == S_FIN);
  assign REM  = rem_r;

endmodule

// File: tb/tb_ring_seq_ctrl.sv
// Testbench for ring_seq_ctrl: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a transaction-level
// model (position within the current sequence, arithmetic ring advance).
module tb_ring_seq_ctrl;

  localparam int W  = 4;
  localparam int CW = 8;
  localparam int MASK = (1 << W) - 1;

  logic          CLK = 1'b0;
  logic          RST, START, ABORT, SIN;
  logic [1:0]    MODE;
  logic [W-1:0]  SEED;
  logic [CW-1:0] STEPS;
  logic [W-1:0]  Q, QP;
  logic          BUSY, DONE;
  logic [CW-1:0] REM;

  always #5 CLK = ~CLK;

  ring_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .MODE(MODE),
    .SEED(SEED), .STEPS(STEPS), .SIN(SIN), .Q(Q), .QP(QP),
    .BUSY(BUSY), .DONE(DONE), .REM(REM)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_k = position of the current cycle inside an accepted sequence:
  // 1 = load cycle, 2..steps+1 = advancing cycles, steps+2 = done cycle.
  bit            m_act = 0;
  int            m_k = 0;
  int            m_steps = 0;
  logic [1:0]    m_mode;
  logic [W-1:0]  m_seed;
  logic [W-1:0]  m_q;
  logic [CW-1:0] m_rem;

  function automatic logic [W-1:0] advance(input logic [W-1:0] q, input logic [1:0] md, input logic s);
    int v, top, nv;
    v   = int'(q);
    top = (v >> (W - 1)) & 1;
    case (md)
      2'd0:    nv = (v * 2) + top;
      2'd1:    nv = (v * 2) + (1 - top);
      2'd2:    nv = (v * 2) + (s ? 1 : 0);
      default: nv = v;
    endcase
    return W'(nv & MASK);
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      m_act = 0; m_q = '0; m_rem = '0; m_mode = '0; m_seed = '0; m_steps = 0;
    end else if (!m_act) begin
      if (START && !ABORT) begin
        m_act = 1; m_k = 1; m_mode = MODE; m_seed = SEED; m_steps = int'(STEPS);
      end
    end else if (m_k == m_steps + 2) begin
      m_act = 0;
    end else if (ABORT) begin
      m_act = 0;
    end else if (m_k == 1) begin
      m_q = m_seed; m_rem = CW'(m_steps); m_k = 2;
    end else begin
      m_q = advance(m_q, m_mode, SIN); m_rem = m_rem - 1'b1; m_k++;
    end
  end

  always @(negedge CLK) begin
    logic [W-1:0] e_qp;
    logic e_busy, e_done;
    if (chk_en) begin
      e_qp   = ~m_q;
      e_busy = m_act && (m_k <= m_steps + 1);
      e_done = m_act && (m_k == m_steps + 2);
      chk("model_q",    Q,    m_q);
      chk("model_qp",   QP,   e_qp);
      chk("model_busy", BUSY, e_busy);
      chk("model_done", DONE, e_done);
      chk("model_rem",  REM,  m_rem);
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [3:0] T2  [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
  localparam logic [3:0] T3  [9] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
  localparam logic [3:0] T4  [4] = '{4'h0, 4'h1, 4'h2, 4'h5};
  localparam logic       SB  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Drives START in the current cycle (c0), returns at c1 with the captured
  // inputs scrambled so later changes are proven irrelevant.
  task automatic start_seq(input logic [1:0] md, input logic [W-1:0] sd, input logic [CW-1:0] st);
    START = 1'b1; MODE = md; SEED = sd; STEPS = st;
    cyc(1);
    START = 1'b0;
    MODE  = 2'($urandom_range(0, 3));
    SEED  = W'($urandom);
    STEPS = CW'($urandom);
  endtask

  initial begin
    int dcnt;
    RST = 1'b1; START = 1'b0; ABORT = 1'b0; SIN = 1'b0;
    MODE = '0; SEED = '0; STEPS = '0;
    cyc(2);
    RST = 1'b0;
    chk_en = 1;
    chk("rst_q", Q, 4'h0);
    chk("rst_qp", QP, 4'hF);
    chk("rst_busy", BUSY, 1'b0);

    // rotate, seed 0001, 4 steps
    start_seq(2'b00, 4'b0001, 8'd4);
    chk("rot_busy_c1", BUSY, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("rot_q", Q, T2[i]);
      chk("rot_done", DONE, (i == 4));
      chk("rot_busy", BUSY, (i < 4));
    end
    cyc(1);
    chk("rot_done_c7", DONE, 1'b0);

    // Johnson, seed 0000, 8 steps
    start_seq(2'b01, 4'b0000, 8'd8);
    for (int i = 0; i < 9; i++) begin
      cyc(1);
      chk("john_q", Q, T3[i]);
      chk("john_done", DONE, (i == 8));
    end
    cyc(1);

    // serial, seed 0000, SIN 1,0,1,1
    start_seq(2'b10, 4'b0000, 8'd4);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("ser_q", Q, T4[i]);
      SIN = SB[i];
    end
    cyc(1);
    chk("ser_final_q", Q, 4'b1011);
    chk("ser_done", DONE, 1'b1);
    SIN = 1'b0;
    cyc(1);

    // zero steps, then START retriggered while busy
    start_seq(2'b00, 4'b1010, 8'd0);
    cyc(1);
    chk("zero_done_c2", DONE, 1'b1);
    chk("zero_q_c2", Q, 4'b1010);
    cyc(1);
    start_seq(2'b00, 4'b0011, 8'd3);
    START = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) START = 1'b0;
      if (DONE) dcnt++;
      cyc(1);
    end
    chk("retrig_one_done", dcnt, 1);

    // abort mid-run
    start_seq(2'b00, 4'b0001, 8'd5);
    cyc(3);
    chk("abort_pre_q", Q, 4'b0100);
    chk("abort_pre_rem", REM, 8'd3);
    ABORT = 1'b1;
    cyc(1);
    ABORT = 1'b0;
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_q", Q, 4'b0100);
    chk("abort_rem", REM, 8'd3);
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (DONE) dcnt++;
      cyc(1);
    end
    chk("abort_no_done", dcnt, 0);
    START = 1'b1; ABORT = 1'b1;
    cyc(1);
    START = 1'b0; ABORT = 1'b0;
    chk("abort_start_idle", BUSY, 1'b0);
    cyc(1);
    chk("abort_start_idle2", BUSY, 1'b0);

    // reset mid-run, then a normal sequence
    start_seq(2'b01, 4'b0000, 8'd8);
    cyc(2);
    RST = 1'b1;
    cyc(2);
    RST = 1'b0;
    chk("midrst_q", Q, 4'h0);
    chk("midrst_qp", QP, 4'hF);
    chk("midrst_busy", BUSY, 1'b0);
    chk("midrst_done", DONE, 1'b0);
    chk("midrst_rem", REM, 8'd0);
    start_seq(2'b00, 4'b0001, 8'd2);
    cyc(1);
    chk("postrst_q_c2", Q, 4'b0001);
    cyc(2);
    chk("postrst_done_c4", DONE, 1'b1);
    chk("postrst_q_c4", Q, 4'b0100);
    cyc(1);

    // full count in hold mode acts as a 255-step delay
    start_seq(2'b11, 4'b0110, 8'd255);
    cyc(1);
    chk("full_rem_c2", REM, 8'd255);
    cyc(255);
    chk("full_done", DONE, 1'b1);
    chk("full_q", Q, 4'b0110);
    chk("full_rem", REM, 8'd0);
    cyc(1);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      RST   = ($urandom_range(0, 149) == 0);
      START = ($urandom_range(0, 5) == 0);
      ABORT = ($urandom_range(0, 29) == 0);
      MODE  = 2'($urandom_range(0, 3));
      SEED  = W'($urandom);
      STEPS = ($urandom_range(0, 9) == 0) ? CW'($urandom) : CW'($urandom_range(0, 12));
      SIN   = 1'($urandom);
      cyc(1);
    end
    RST = 1'b0; START = 1'b0; ABORT = 1'b0;
    cyc(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
